// File: rtl/onehot_decode_seq.sv
// onehot_decode_seq: registered SEL_W-to-2**SEL_W one-hot decoder with
// a valid/ready handshake and per-line dwell timing.
//   Direct mode: an accepted code drives its line for DWELL cycles.
//   Scan mode:   walks every line in turn, DWELL cycles each, pulsing
//                scan_done on the final dwell cycle of the last line.
// Build option: define ONEHOT_DECODE_ACTIVE_LOW_EN to drive out_bits
// inverted (idle all-ones, asserted line low). out_valid keeps its
// active-high meaning in both builds.
module onehot_decode_seq #(
    parameter int SEL_W = 3,
    parameter int DWELL = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  sel_valid,
    input  logic [SEL_W-1:0]      sel,
    output logic                  sel_ready,
    output logic [2**SEL_W-1:0]   out_bits,
    output logic                  out_valid,
    output logic                  scan_done
);

    localparam int OUT_W = 2**SEL_W;
    localparam int CNT_W = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

`ifdef ONEHOT_DECODE_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] POL_MASK = '1;
`else
    localparam logic [OUT_W-1:0] POL_MASK = '0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SCAN
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [OUT_W-1:0]  out_q;
    logic [OUT_W-1:0]  line_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              accept;

    // State and registered datapath; out_q holds the polarity-adjusted lines
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= POL_MASK;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            out_q   <= line_d ^ POL_MASK;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-datapath decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        line_d  = out_q ^ POL_MASK;
        valid_d = valid_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d   = '0;
                idx_d   = '0;
                line_d  = '0;
                valid_d = 1'b0;
                if (accept) begin
                    state_d = HOLD;
                    line_d  = OUT_W'(1) << sel;
                    valid_d = 1'b1;
                    cnt_d   = CNT_LOAD;
                end else if (en && mode) begin
                    state_d = SCAN;
                    line_d  = OUT_W'(1);
                    valid_d = 1'b1;
                    cnt_d   = CNT_LOAD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    line_d  = '0;
                    valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SCAN: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    line_d  = '0;
                    valid_d = 1'b0;
                end else begin
                    if (cnt_q == '0) begin
                        // index wraps naturally because OUT_W == 2**SEL_W
                        idx_d  = idx_q + SEL_W'(1);
                        line_d = OUT_W'(1) << idx_d;
                        cnt_d  = CNT_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                    // registered pulse: asserted for the cycle that will be
                    // the last dwell of the last line
                    done_d = (idx_d == '1) && (cnt_d == '0);
                end
            end
            default: begin
                state_d = IDLE;
                line_d  = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // Handshake decode and output drive
    always_comb begin
        sel_ready = (state_q == IDLE) && en && !mode && !rst;
        accept    = sel_ready && sel_valid;
        out_bits  = out_q;
        out_valid = valid_q;
        scan_done = done_q;
    end

endmodule
